// File: rtl/screen_tx.sv
// UART-style transmitter for the RS485 screen link: start, 8 data LSB first, parity/stop2, stop.
// Drives the transceiver driver-enable with lead/lag guard times; accepts chained bytes during LAG.
module screen_tx #(
  parameter int unsigned CLKS_PER_BIT = 246,
  parameter int unsigned DE_LEAD_CLKS = 16,
  parameter int unsigned DE_LAG_CLKS  = 16,
  parameter bit          PARITY_EN    = 1'b1,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk_29491200Hz,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       de,
  output logic       busy,
  output logic       tx_done
);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, LAG} state_t;

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] LEAD_LAST = 16'(DE_LEAD_CLKS - 1);
  localparam logic [15:0] LAG_LAST  = 16'(DE_LAG_CLKS - 1);
  localparam logic [3:0]  STOP_IDX  = 4'd10;

  state_t      state, state_nxt;
  logic [15:0] clk_cnt, clk_cnt_nxt;
  logic [3:0]  bit_idx, bit_idx_nxt;
  logic [10:0] frame, frame_nxt;
  logic        tx_out_nxt, de_nxt, done_nxt;
  logic        accept;

  // Whole frame built at accept so SHIFT only has to index it.
  function automatic logic [10:0] build_frame(input logic [7:0] d);
    logic par;
    par = PARITY_EN ? ((^d) ^ PARITY_ODD) : 1'b1;
    return {1'b1, par, d, 1'b0};
  endfunction

  assign tx_ready = (state == IDLE) || (state == LAG);
  assign accept   = tx_valid && tx_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_idx_nxt = bit_idx;
    frame_nxt   = frame;
    tx_out_nxt  = 1'b1;
    de_nxt      = 1'b1;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        de_nxt = 1'b0;
        if (accept) begin
          state_nxt   = LEAD;
          clk_cnt_nxt = '0;
          frame_nxt   = build_frame(tx_data);
          de_nxt      = 1'b1;
        end
      end
      LEAD: begin
        if (clk_cnt == LEAD_LAST) begin
          state_nxt   = SHIFT;
          clk_cnt_nxt = '0;
          bit_idx_nxt = '0;
          tx_out_nxt  = frame[0];
        end else begin
          clk_cnt_nxt = clk_cnt + 16'd1;
        end
      end
      SHIFT: begin
        tx_out_nxt = frame[bit_idx];
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nxt = '0;
          if (bit_idx == STOP_IDX) begin
            state_nxt  = LAG;
            done_nxt   = 1'b1;
            tx_out_nxt = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx + 4'd1;
            tx_out_nxt  = frame[bit_idx + 4'd1];
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 16'd1;
        end
      end
      LAG: begin
        // A chained byte wins over the lag timeout, so de never drops between frames.
        if (accept) begin
          state_nxt   = SHIFT;
          clk_cnt_nxt = '0;
          bit_idx_nxt = '0;
          frame_nxt   = build_frame(tx_data);
          tx_out_nxt  = 1'b0;
        end else if (clk_cnt == LAG_LAST) begin
          state_nxt   = IDLE;
          clk_cnt_nxt = '0;
          de_nxt      = 1'b0;
        end else begin
          clk_cnt_nxt = clk_cnt + 16'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        de_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_29491200Hz or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      frame   <= '0;
      tx_out  <= 1'b1;
      de      <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      frame   <= frame_nxt;
      tx_out  <= tx_out_nxt;
      de      <= de_nxt;
      tx_done <= done_nxt;
    end
  end

endmodule
